hazard_controller: RTL
======================

// Module: hazard_controller
// PURPOSE
//  Pipeline sequencer for the 5-stage RV32 core: generates stage write-enables, flushes and bubbles.
//  Covers load-use stalls the forwarding network cannot resolve, taken-branch flushes and data-memory wait states.
//  Watchdogs the memory handshake and keeps stall/flush performance counters.
//  Sits beside the forwarding unit, driven by ID/EX/MEM pipeline-register fields.
// PARAMETERS
//  REG_W        5    register-index width
//  MEM_TIMEOUT  16   max consecutive MEM wait cycles before error (>=2)
//  CNT_W        32   performance counter width
// PORTS
//  clk            in   1      clock, rising edge
//  rst_n          in   1      async active-low reset
//  ID_rs1         in   REG_W  rs1 of instruction in ID
//  ID_rs2         in   REG_W  rs2 of instruction in ID
//  ID_UseRs1      in   1      ID instruction reads rs1
//  ID_UseRs2      in   1      ID instruction reads rs2
//  EX_rd          in   REG_W  rd of instruction in EX
//  EX_MemRead     in   1      EX instruction is a load
//  EX_BranchTaken in   1      EX resolved taken branch/jump
//  MEM_MemReq     in   1      MEM stage has an active data-memory access
//  MEM_MemReady   in   1      data memory completes access this cycle
//  ErrClear       in   1      clears ERROR state
//  PCWrite        out  1      PC update enable
//  IF_ID_Write    out  1      IF/ID register enable
//  IF_ID_Flush    out  1      IF/ID loaded with NOP
//  ID_EX_Write    out  1      ID/EX register enable
//  ID_EX_Flush    out  1      ID/EX loaded with NOP (bubble)
//  EX_MEM_Write   out  1      EX/MEM register enable
//  MEM_WB_Bubble  out  1      MEM/WB loaded with NOP
//  MemTimeoutErr  out  1      high while in ERROR
//  StallCount     out  CNT_W  cycles with PCWrite=0
//  FlushCount     out  CNT_W  taken-branch flushes performed
// BEHAVIOUR
//  States: RUN, MEM_WAIT, ERROR. Outputs combinational from state+inputs; counters/state registered.
//  Reset (async, any time): state=RUN, wait counter=0, StallCount=FlushCount=0. Outputs then follow RUN.
//  Conditions:
//   mem_wait = MEM_MemReq & ~MEM_MemReady
//   load_use = EX_MemRead & EX_rd!=0 & ((ID_UseRs1 & ID_rs1==EX_rd) | (ID_UseRs2 & ID_rs2==EX_rd))
//  Priority per cycle: ERROR > mem_wait > EX_BranchTaken > load_use > none.
//  ERROR or mem_wait: freeze -> PCWrite=IF_ID_Write=ID_EX_Write=EX_MEM_Write=0, MEM_WB_Bubble=1, no flushes.
//  BranchTaken (no freeze): IF_ID_Flush=1, ID_EX_Flush=1, all writes 1; FlushCount+1. Load-use same cycle ignored.
//  load_use: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; exactly one bubble, next cycle load is in MEM (fwd sel 01).
//  None: all writes 1, all flush/bubble 0.
//  RUN: mem_wait -> MEM_WAIT, wait counter=1.
//  MEM_WAIT: MEM_MemReady -> RUN (that cycle unfrozen, counter=0); else counter+1;
//   counter reaching MEM_TIMEOUT with no ready -> ERROR. Ready in same cycle as limit: RUN wins.
//  ERROR: MemTimeoutErr=1, pipeline frozen; ErrClear -> RUN next cycle, counter=0. ErrClear ignored elsewhere.
//  StallCount +1 every cycle PCWrite=0 (freeze, load-use). Both counters wrap at 2^CNT_W silently.
//  rd=x0 never causes a load-use stall. Flush never asserted while frozen (branch held in EX until unfreeze).
// TESTING
//  EX_MemRead=1, EX_rd=5, ID_rs1=5, ID_UseRs1=1 -> 1 cycle PCWrite=0, ID_EX_Flush=1; StallCount=1; next cycle all writes 1.
//  Same but EX_rd=0, or ID_UseRs1=0 -> no stall, StallCount stays 0.
//  EX_BranchTaken=1 with load_use also true -> IF_ID_Flush=ID_EX_Flush=1, PCWrite=1, FlushCount=1, StallCount=0.
//  MEM_MemReq=1, MemReady low 3 cycles then high -> 3 frozen cycles (MEM_WB_Bubble=1), RUN after, StallCount=3.
//  MemReady never high -> ERROR after 16 cycles, MemTimeoutErr=1; ErrClear pulse -> RUN, MemTimeoutErr=0.
//  rst_n low mid MEM_WAIT -> immediately RUN, counters 0, all writes 1 once MemReq deasserted.

Source files
------------

// File: rtl/hazard_controller.sv
// Pipeline sequencer for the 5-stage RV32 core: stage enables, flushes and bubbles,
// data-memory wait watchdog and stall/flush performance counters.
module hazard_controller #(
  parameter int unsigned REG_W       = 5,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] ID_rs1,
  input  logic [REG_W-1:0] ID_rs2,
  input  logic             ID_UseRs1,
  input  logic             ID_UseRs2,
  input  logic [REG_W-1:0] EX_rd,
  input  logic             EX_MemRead,
  input  logic             EX_BranchTaken,
  input  logic             MEM_MemReq,
  input  logic             MEM_MemReady,
  input  logic             ErrClear,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Write,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Write,
  output logic             MEM_WB_Bubble,
  output logic             MemTimeoutErr,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              mem_wait, load_use, freeze, flush;

  assign mem_wait = MEM_MemReq & ~MEM_MemReady;
  assign load_use = EX_MemRead & (EX_rd != '0) &
                    ((ID_UseRs1 & (ID_rs1 == EX_rd)) | (ID_UseRs2 & (ID_rs2 == EX_rd)));
  assign freeze   = (state == ERROR) | mem_wait;
  assign flush    = ~freeze & EX_BranchTaken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next state and stage controls; priority ERROR > mem_wait > branch > load-use.
  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    PCWrite       = 1'b1;
    IF_ID_Write   = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Write   = 1'b1;
    ID_EX_Flush   = 1'b0;
    EX_MEM_Write  = 1'b1;
    MEM_WB_Bubble = 1'b0;
    MemTimeoutErr = (state == ERROR);

    case (state)
      RUN: begin
        if (mem_wait) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!mem_wait) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_nxt    = ERROR;
          wait_cnt_nxt = WAIT_W'(MEM_TIMEOUT);
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      ERROR: begin
        if (ErrClear) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase

    if (freeze) begin
      PCWrite       = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Write   = 1'b0;
      EX_MEM_Write  = 1'b0;
      MEM_WB_Bubble = 1'b1;
    end else if (flush) begin
      IF_ID_Flush   = 1'b1;
      ID_EX_Flush   = 1'b1;
    end else if (load_use) begin
      PCWrite       = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Flush   = 1'b1;
    end
  end

  // Performance counters wrap silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (!PCWrite) StallCount <= StallCount + CNT_W'(1);
      if (flush)    FlushCount <= FlushCount + CNT_W'(1);
    end
  end

endmodule
